// File: rtl/program_loader_pkg.sv
// Shared types and defaults for the UART-driven instruction-memory loader.
package program_loader_pkg;

  typedef logic [31:0] w32;
  typedef logic [31:0] r32;

  typedef enum logic [2:0] {
    S_HEADER,
    S_BODY,
    S_ACK,
    S_ERR,
    S_DONE
  } loader_state_t;

  localparam w32         INSTR_MEM_SIZE_DEF = 32'h8000;
  localparam logic [7:0] ACK_BYTE_DEF       = 8'hAA;
  localparam logic [7:0] ERR_BYTE_DEF       = 8'h55;

  // Unsigned 32-bit compare; a header above capacity is rejected outright.
  function automatic logic count_too_big(input w32 count, input w32 limit);
    return count > limit;
  endfunction

endpackage

// File: rtl/program_loader_byte_word_assembler.sv
// Packs little-endian bytes into 32-bit words; word_valid_o pulses combinationally
// alongside the 4th byte so the caller can register the result on that same edge.
module byte_word_assembler
  import program_loader_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  output logic [1:0] idx_o,
  output logic       word_valid_o,
  output w32         word_o
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] bytes_q, bytes_d;
  logic        take;

  assign take         = en_i & rx_valid_i;
  assign idx_o        = idx_q;
  assign word_valid_o = take & (idx_q == 2'd3) & ~clear_i;
  assign word_o       = {rx_data_i, bytes_q};

  always_comb begin
    idx_d   = idx_q;
    bytes_d = bytes_q;
    if (clear_i) begin
      idx_d = 2'd0;
    end else if (take) begin
      idx_d = idx_q + 2'd1;
      unique case (idx_q)
        2'd0:    bytes_d[7:0]   = rx_data_i;
        2'd1:    bytes_d[15:8]  = rx_data_i;
        2'd2:    bytes_d[23:16] = rx_data_i;
        default: bytes_d        = bytes_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q   <= 2'd0;
      bytes_q <= 24'd0;
    end else begin
      idx_q   <= idx_d;
      bytes_q <= bytes_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a count-prefixed little-endian word stream from the UART into instruction
// memory, answers with a status byte, then raises done to release the core.
module program_loader
  import program_loader_pkg::*;
#(
  parameter w32         INSTR_MEM_SIZE = INSTR_MEM_SIZE_DEF,
  parameter logic [7:0] ACK_BYTE       = ACK_BYTE_DEF,
  parameter logic [7:0] ERR_BYTE       = ERR_BYTE_DEF,
  parameter int         WL_W           = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            rx_valid,
  input  logic [7:0]      rx_data,
  output logic            push,
  output w32              push_data,
  output logic            tx_valid,
  output logic [7:0]      tx_data,
  input  logic            tx_ready,
  output logic            loading,
  output logic            done,
  output logic [WL_W-1:0] words_loaded
);

  localparam logic [WL_W-1:0] WL_ONE = {{(WL_W-1){1'b0}}, 1'b1};

  loader_state_t   state_q, state_d;
  w32              remaining_q, remaining_d;
  logic            push_q, push_d;
  w32              push_data_q, push_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            done_q, done_d;
  logic [WL_W-1:0] wl_q, wl_d;

  logic       asm_en, asm_clear, word_valid, tx_hs;
  logic [1:0] asm_idx;
  w32         word;

  byte_word_assembler u_asm (
    .clock        (clock),
    .reset        (reset),
    .clear_i      (asm_clear),
    .en_i         (asm_en),
    .rx_valid_i   (rx_valid),
    .rx_data_i    (rx_data),
    .idx_o        (asm_idx),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  assign asm_en = (state_q == S_HEADER) || (state_q == S_BODY);
  assign tx_hs  = tx_valid_q & tx_ready;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    done_d      = done_q;
    wl_d        = wl_q;
    asm_clear   = 1'b0;
    unique case (state_q)
      S_HEADER: begin
        if (word_valid) begin
          if (word == 32'd0) begin
            state_d    = S_ACK;
            tx_valid_d = 1'b1;
            tx_data_d  = ACK_BYTE;
          end else if (count_too_big(word, INSTR_MEM_SIZE)) begin
            state_d    = S_ERR;
            tx_valid_d = 1'b1;
            tx_data_d  = ERR_BYTE;
          end else begin
            state_d     = S_BODY;
            remaining_d = word;
          end
        end
      end
      S_BODY: begin
        if (word_valid) begin
          push_d      = 1'b1;
          push_data_d = word;
          wl_d        = wl_q + WL_ONE;
          remaining_d = remaining_q - 32'd1;
          // Last word: ACK state begins in the very cycle push is high.
          if (remaining_q == 32'd1) begin
            state_d    = S_ACK;
            tx_valid_d = 1'b1;
            tx_data_d  = ACK_BYTE;
          end
        end
      end
      S_ACK: begin
        if (tx_hs) begin
          tx_valid_d = 1'b0;
          state_d    = S_DONE;
          done_d     = 1'b1;
        end
      end
      S_ERR: begin
        if (tx_hs) begin
          tx_valid_d = 1'b0;
          state_d    = S_HEADER;
          asm_clear  = 1'b1;
          wl_d       = '0;
        end
      end
      S_DONE: done_d = 1'b1;
      default: state_d = S_HEADER;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_HEADER;
      remaining_q <= 32'd0;
      push_q      <= 1'b0;
      push_data_q <= 32'd0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'd0;
      done_q      <= 1'b0;
      wl_q        <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      done_q      <= done_d;
      wl_q        <= wl_d;
    end
  end

  assign push         = push_q;
  assign push_data    = push_data_q;
  assign tx_valid     = tx_valid_q;
  assign tx_data      = tx_data_q;
  assign done         = done_q;
  assign words_loaded = wl_q;
  assign loading      = ((state_q == S_HEADER) && (asm_idx != 2'd0)) || (state_q == S_BODY);

endmodule
